hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-bit-PC, 32-register pipelined CPU. It decides each cycle whether fetch/decode advance, stall or are flushed, and selects EX-stage operand forwarding. It also drains the pipeline on a halt instruction and keeps saturating stall/flush performance counters. It sits beside the decode stage, driving the PC-update enable and the IF/ID and ID/EX pipeline-register controls.

Parameters:
FLUSH_CYCLES, 1, cycles flush stays asserted per taken jump (range 1-3)
DRAIN_CYCLES, 3, bubble cycles inserted after halt before halted asserts (range 1-7)
CNT_W, 16, performance-counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  decode-stage source register 1
id_rs2  in  5  decode-stage source register 2
id_use_rs1  in  1  decode instruction reads rs1
id_use_rs2  in  1  decode instruction reads rs2
id_halt  in  1  decode instruction is halt
ex_rs1  in  5  EX-stage source register 1
ex_rs2  in  5  EX-stage source register 2
ex_rd  in  5  EX-stage destination
ex_wrenable  in  1  EX instruction writes a register
ex_load  in  1  EX instruction is a load
ex_jump  in  1  EX resolved a taken jump/branch this cycle
mem_rd  in  5  MEM-stage destination
mem_wrenable  in  1  MEM instruction writes a register
wb_rd  in  5  WB-stage destination
wb_wrenable  in  1  WB instruction writes a register
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
idex_bubble  out  1  load NOP into ID/EX
flush  out  1  squash IF/ID and ID/EX contents
fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM, 10 WB
fwd_b  out  2  EX operand B select, same encoding
halted  out  1  core halted
stall_count  out  CNT_W  load-use stall cycles, saturating
flush_count  out  CNT_W  taken-jump events, saturating

Behaviour:
- States: RUN, FLUSH, DRAIN, HALTED. Reset: RUN, internal counters 0, stall_count=0, flush_count=0, halted=0; all control outputs 0 while rst_n low. Reset mid-drain or mid-flush returns to RUN immediately.
- Control outputs are combinational from state and current inputs; state and counters are registered.
- Forwarding (combinational, independent of state): fwd_a=01 if mem_wrenable & mem_rd!=0 & mem_rd==ex_rs1; else 10 if wb_wrenable & wb_rd!=0 & wb_rd==ex_rs1; else 00. fwd_b likewise with ex_rs2. MEM has priority over WB. Register x0 never forwards.
- Load-use hazard LU = ex_load & ex_wrenable & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN, priority order:
  1. ex_jump: flush=1 this cycle; flush_count+1; next FLUSH with remaining = FLUSH_CYCLES-1, or RUN if FLUSH_CYCLES=1. LU and id_halt are ignored.
  2. LU: pc_stall=ifid_stall=idex_bubble=1 for one cycle; stall_count+1; stay in RUN, where LU re-evaluates next cycle.
  3. id_halt: pc_stall=1, flush=1; next DRAIN with remaining = DRAIN_CYCLES-1.
- FLUSH: flush=1, pc_stall=0; decrement remaining and return to RUN after it hits 0. ex_jump in FLUSH restarts remaining at FLUSH_CYCLES-1 and increments flush_count. LU and id_halt are ignored.
- DRAIN: pc_stall=1, flush=1; ex_jump is ignored because older instructions were already committed. Decrement remaining; at 0, next state is HALTED.
- HALTED: halted=1, pc_stall=1, ifid_stall=1; all other controls 0. Exit only by reset.
- Counters saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Reset: rst_n low asynchronously mid-FLUSH -> all outputs 0 within the same cycle; after release, state is RUN and counters read 0.
- Forwarding: ex_rs1=5, mem_rd=5/mem_wrenable=1, wb_rd=5/wb_wrenable=1 -> fwd_a=01; drop mem_wrenable -> fwd_a=10; ex_rs2=0 with mem_rd=0 -> fwd_b=00.
- Load-use: ex_load=1, ex_rd=7, id_rs2=7, id_use_rs2=1 for one cycle -> exactly one cycle of pc_stall=ifid_stall=idex_bubble=1 and stall_count=1. Same with ex_rd=0 -> no stall.
- Jump vs load-use: ex_jump=1 together with LU, FLUSH_CYCLES=2 -> flush=1 for 2 cycles, no stall, flush_count=1, stall_count=0.
- Halt drain: id_halt=1 in RUN with DRAIN_CYCLES=3 -> pc_stall=flush=1 for 3 cycles, then halted=1 held; later ex_jump/id_halt pulses cause no change.
- Saturation: CNT_W=4 and 20 load-use cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, jump flushes, halt drain,
// EX operand forwarding selects and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_halt,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_wrenable,
    input  logic             ex_load,
    input  logic             ex_jump,
    input  logic [4:0]       mem_rd,
    input  logic             mem_wrenable,
    input  logic [4:0]       wb_rd,
    input  logic             wb_wrenable,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    // Remaining counts exclude the cycle that triggered the sequence.
    localparam logic [2:0]       FLUSH_REM = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0]       DRAIN_REM = 3'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [2:0]       rem_reg, rem_next;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    logic             pc_stall_c, ifid_stall_c, idex_bubble_c, flush_c, halted_c;
    logic             stall_inc, flush_inc;
    logic             load_use;

    // Forwarding: MEM beats WB, x0 never forwards.
    logic [4:0] ex_src  [2];
    logic [1:0] fwd_sel [2];

    assign ex_src[0] = ex_rs1;
    assign ex_src[1] = ex_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_hit, wb_hit;
            assign mem_hit     = mem_wrenable && (mem_rd != 5'd0) && (mem_rd == ex_src[gi]);
            assign wb_hit      = wb_wrenable  && (wb_rd  != 5'd0) && (wb_rd  == ex_src[gi]);
            assign fwd_sel[gi] = mem_hit ? 2'b01 : (wb_hit ? 2'b10 : 2'b00);
        end
    endgenerate

    assign load_use = ex_load && ex_wrenable && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_next    = state_reg;
        rem_next      = rem_reg;
        pc_stall_c    = 1'b0;
        ifid_stall_c  = 1'b0;
        idex_bubble_c = 1'b0;
        flush_c       = 1'b0;
        halted_c      = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        case (state_reg)
            RUN: begin
                if (ex_jump) begin
                    flush_c   = 1'b1;
                    flush_inc = 1'b1;
                    rem_next  = FLUSH_REM;
                    state_next = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                end else if (load_use) begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    stall_inc     = 1'b1;
                end else if (id_halt) begin
                    pc_stall_c = 1'b1;
                    flush_c    = 1'b1;
                    rem_next   = DRAIN_REM;
                    state_next = (DRAIN_CYCLES == 1) ? HALTED : DRAIN;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                if (ex_jump) begin
                    flush_inc = 1'b1;
                    rem_next  = FLUSH_REM;
                end else if (rem_reg <= 3'd1) begin
                    rem_next   = 3'd0;
                    state_next = RUN;
                end else begin
                    rem_next = rem_reg - 3'd1;
                end
            end
            DRAIN: begin
                // Older instructions already committed, so a jump here is moot.
                pc_stall_c = 1'b1;
                flush_c    = 1'b1;
                if (rem_reg <= 3'd1) begin
                    rem_next   = 3'd0;
                    state_next = HALTED;
                end else begin
                    rem_next = rem_reg - 3'd1;
                end
            end
            HALTED: begin
                halted_c     = 1'b1;
                pc_stall_c   = 1'b1;
                ifid_stall_c = 1'b1;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            rem_reg       <= 3'd0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            if (stall_inc && (stall_cnt_reg != CNT_MAX))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (flush_inc && (flush_cnt_reg != CNT_MAX))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    assign pc_stall    = rst_n & pc_stall_c;
    assign ifid_stall  = rst_n & ifid_stall_c;
    assign idex_bubble = rst_n & idex_bubble_c;
    assign flush       = rst_n & flush_c;
    assign halted      = rst_n & halted_c;
    assign fwd_a       = rst_n ? fwd_sel[0] : 2'b00;
    assign fwd_b       = rst_n ? fwd_sel[1] : 2'b00;
    assign stall_count = stall_cnt_reg;
    assign flush_count = flush_cnt_reg;

endmodule
